// File: rtl/mammal_intc.sv
// mammal_intc: priority interrupt controller for the mammal CPU.
//
// Collects NSRC edge-triggered peripheral requests and drives the single
// CPU INT line. Index 0 has the highest priority. It answers the CPU's
// one-cycle intack with a vector index.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   src_irq   in   [NSRC] level requests, a rising edge requests service
//   address   in   [12] CPU address bus
//   wdata     in   [16] CPU write data
//   memwt     in   CPU write strobe
//   rsel      out  address hits BASE..BASE+3 (combinational)
//   rdata     out  [16] register read data, zero when rsel=0
//   INT       out  registered interrupt request to the CPU
//   intack    in   CPU acknowledge, one cycle
//   vec_out   out  [16] winner index during acknowledge, zero otherwise
//
// Register map (offset from BASE):
//   0 MASK      R/W  1 = source enabled
//   1 PENDING   R/W1C
//   2 INSERVICE R, any write is an EOI clearing the lowest set bit
//   3 STATUS    R    {11'b0, state, 1'b0, winner}
module mammal_intc #(
    parameter int unsigned NSRC = 4,
    parameter logic [11:0] BASE = 12'hF80
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src_irq,
    input  logic [11:0]     address,
    input  logic [15:0]     wdata,
    input  logic            memwt,
    output logic            rsel,
    output logic [15:0]     rdata,
    output logic            INT,
    input  logic            intack,
    output logic [15:0]     vec_out
);

    typedef enum logic {
        StIdle = 1'b0,
        StReq  = 1'b1
    } state_e;

    state_e          r_state;
    logic [NSRC-1:0] r_mask;
    logic [NSRC-1:0] r_pend;
    logic [NSRC-1:0] r_insvc;
    logic [NSRC-1:0] r_prev;
    logic [2:0]      r_winner;
    logic            r_int;

    logic [11:0]     w_off;
    logic            w_wr;
    logic            w_wr_mask;
    logic            w_wr_pend;
    logic            w_wr_eoi;
    logic            w_ack;
    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_allow;
    logic [NSRC-1:0] w_elig;
    logic [2:0]      w_cand;
    logic            w_seen;
    logic            w_found;
    logic [NSRC-1:0] w_pend_nxt;
    logic [NSRC-1:0] w_insvc_nxt;
    logic [15:0]     w_mask_ext;
    logic [15:0]     w_pend_ext;
    logic [15:0]     w_insvc_ext;
    logic            w_unused;

    // Address decode; an address below BASE wraps to a large offset.
    assign w_off     = address - BASE;
    assign rsel      = (w_off < 12'd4);
    assign w_wr      = memwt & rsel;
    assign w_wr_mask = w_wr & (w_off[1:0] == 2'd0);
    assign w_wr_pend = w_wr & (w_off[1:0] == 2'd1);
    assign w_wr_eoi  = w_wr & (w_off[1:0] == 2'd2);
    assign w_ack     = intack & (r_state == StReq);

    assign w_rise = src_irq & ~r_prev;

    // Strict nesting: source i may interrupt only if nothing of equal or
    // higher priority is currently in service.
    always_comb begin
        w_seen  = 1'b0;
        w_allow = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_seen     = w_seen | r_insvc[i];
            w_allow[i] = ~w_seen;
        end
    end

    assign w_elig = r_pend & r_mask & w_allow;

    // Lowest set index of elig wins.
    always_comb begin
        w_cand = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_cand = 3'(i);
            end
        end
    end

    // Pending: clears first, then rises, so a same-cycle set wins.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_wr_pend) begin
            w_pend_nxt = w_pend_nxt & ~wdata[NSRC-1:0];
        end
        for (int i = 0; i < NSRC; i++) begin
            if (w_ack && (r_winner == 3'(i))) begin
                w_pend_nxt[i] = 1'b0;
            end
        end
        w_pend_nxt = w_pend_nxt | w_rise;
    end

    // In-service: EOI retires the highest-priority active level, ack adds one.
    always_comb begin
        w_insvc_nxt = r_insvc;
        w_found     = 1'b0;
        if (w_wr_eoi) begin
            for (int i = 0; i < NSRC; i++) begin
                if (!w_found && r_insvc[i]) begin
                    w_insvc_nxt[i] = 1'b0;
                    w_found        = 1'b1;
                end
            end
        end
        for (int i = 0; i < NSRC; i++) begin
            if (w_ack && (r_winner == 3'(i))) begin
                w_insvc_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= StIdle;
            r_mask   <= '0;
            r_pend   <= '0;
            r_insvc  <= '0;
            r_prev   <= '0;
            r_winner <= 3'd0;
            r_int    <= 1'b0;
        end else begin
            r_prev  <= src_irq;
            r_pend  <= w_pend_nxt;
            r_insvc <= w_insvc_nxt;
            if (w_wr_mask) begin
                r_mask <= wdata[NSRC-1:0];
            end
            unique case (r_state)
                StIdle: begin
                    if (w_elig != '0) begin
                        r_winner <= w_cand;
                        r_state  <= StReq;
                        r_int    <= 1'b1;
                    end
                end
                StReq: begin
                    // Winner stays frozen until the CPU acknowledges it.
                    if (intack) begin
                        r_state <= StIdle;
                        r_int   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_int   <= 1'b0;
                end
            endcase
        end
    end

    assign INT     = r_int;
    assign vec_out = w_ack ? {13'b0, r_winner} : 16'h0000;

    always_comb begin
        w_mask_ext              = '0;
        w_pend_ext              = '0;
        w_insvc_ext             = '0;
        w_mask_ext[NSRC-1:0]    = r_mask;
        w_pend_ext[NSRC-1:0]    = r_pend;
        w_insvc_ext[NSRC-1:0]   = r_insvc;
    end

    always_comb begin
        rdata = 16'h0000;
        if (rsel) begin
            unique case (w_off[1:0])
                2'd0:    rdata = w_mask_ext;
                2'd1:    rdata = w_pend_ext;
                2'd2:    rdata = w_insvc_ext;
                default: rdata = {11'b0, (r_state == StReq), 1'b0, r_winner};
            endcase
        end
    end

    // Write data bits above the source count have no destination.
    assign w_unused = ^{1'b0, wdata};

endmodule

// File: tb/tb_mammal_intc.sv
// Directed self-checking bench for mammal_intc (NSRC=4, BASE=0xF80).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_mammal_intc;

    localparam logic [11:0] AMASK = 12'hF80;
    localparam logic [11:0] APEND = 12'hF81;
    localparam logic [11:0] AISVC = 12'hF82;
    localparam logic [11:0] ASTAT = 12'hF83;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  src_irq;
    logic [11:0] address;
    logic [15:0] wdata;
    logic        memwt;
    logic        rsel;
    logic [15:0] rdata;
    logic        int_o;
    logic        intack;
    logic [15:0] vec_out;

    int checks = 0;
    int errors = 0;

    mammal_intc #(
        .NSRC (4),
        .BASE (12'hF80)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .src_irq (src_irq),
        .address (address),
        .wdata   (wdata),
        .memwt   (memwt),
        .rsel    (rsel),
        .rdata   (rdata),
        .INT     (int_o),
        .intack  (intack),
        .vec_out (vec_out)
    );

    always #10 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [11:0] a, input string tag, input logic [15:0] exp);
        address = a;
        #1;
        chk(tag, rdata, exp);
        address = 12'h000;
    endtask

    task automatic wr(input logic [11:0] a, input logic [15:0] d);
        address = a;
        wdata   = d;
        memwt   = 1'b1;
        step(1);
        memwt   = 1'b0;
        address = 12'h000;
        wdata   = 16'h0000;
    endtask

    task automatic pulse(input logic [3:0] v);
        src_irq = v;
        step(1);
        src_irq = 4'h0;
    endtask

    task automatic ack(input string tag, input logic [15:0] exp_vec);
        intack = 1'b1;
        #1;
        chk(tag, vec_out, exp_vec);
        step(1);
        intack = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        src_irq = 4'h0;
        address = 12'h000;
        wdata   = 16'h0000;
        memwt   = 1'b0;
        intack  = 1'b0;
        step(2);
        reset = 1'b0;

        // Reset state and decode
        chk("rst_int", {15'b0, int_o}, 16'h0000);
        chk("rst_vec", vec_out, 16'h0000);
        rd(AMASK, "rst_mask", 16'h0000);
        rd(APEND, "rst_pend", 16'h0000);
        rd(AISVC, "rst_isvc", 16'h0000);
        rd(ASTAT, "rst_stat", 16'h0000);
        address = 12'hF84;
        #1;
        chk("rsel_out", {15'b0, rsel}, 16'h0000);
        chk("rdata_out", rdata, 16'h0000);
        address = 12'hF83;
        #1;
        chk("rsel_in", {15'b0, rsel}, 16'h0001);
        address = 12'h000;
        intack = 1'b1;
        #1;
        chk("idle_ack_vec", vec_out, 16'h0000);
        step(1);
        intack = 1'b0;
        chk("idle_ack_int", {15'b0, int_o}, 16'h0000);

        // Single source, basic latency and ack
        wr(AMASK, 16'hFFF4);
        rd(AMASK, "mask_trunc", 16'h0004);
        pulse(4'h4);
        rd(APEND, "t1_pend", 16'h0004);
        chk("t1_int_lo", {15'b0, int_o}, 16'h0000);
        step(1);
        chk("t1_int_hi", {15'b0, int_o}, 16'h0001);
        rd(ASTAT, "t1_stat", 16'h0012);
        ack("t1_vec", 16'h0002);
        chk("t1_int_post", {15'b0, int_o}, 16'h0000);
        rd(APEND, "t1_pend_post", 16'h0000);
        rd(AISVC, "t1_isvc", 16'h0004);
        wr(AISVC, 16'h0000);
        rd(AISVC, "t1_eoi", 16'h0000);

        // Masked source held pending, then enabled
        wr(AMASK, 16'h0000);
        pulse(4'h2);
        step(2);
        chk("t2_int_masked", {15'b0, int_o}, 16'h0000);
        rd(APEND, "t2_pend", 16'h0002);
        wr(AMASK, 16'h0002);
        chk("t2_int_wr", {15'b0, int_o}, 16'h0000);
        step(1);
        chk("t2_int_hi", {15'b0, int_o}, 16'h0001);
        ack("t2_vec", 16'h0001);
        wr(AISVC, 16'h0000);

        // Simultaneous rises, priority and nesting block
        wr(AMASK, 16'h000F);
        pulse(4'h9);
        rd(APEND, "t3_pend", 16'h0009);
        step(1);
        rd(ASTAT, "t3_stat", 16'h0010);
        ack("t3_vec0", 16'h0000);
        rd(AISVC, "t3_isvc", 16'h0001);
        rd(APEND, "t3_pend2", 16'h0008);
        step(2);
        chk("t3_blocked", {15'b0, int_o}, 16'h0000);
        wr(AISVC, 16'h0000);
        chk("t3_int_eoi", {15'b0, int_o}, 16'h0000);
        step(1);
        chk("t3_int_hi", {15'b0, int_o}, 16'h0001);
        ack("t3_vec3", 16'h0003);
        rd(AISVC, "t3_isvc3", 16'h0008);
        wr(AISVC, 16'h0000);

        // Nesting: higher priority preempts, lower waits for two EOIs
        pulse(4'h4);
        step(1);
        ack("t4_vec2", 16'h0002);
        pulse(4'h2);
        step(1);
        chk("t4_nest_int", {15'b0, int_o}, 16'h0001);
        ack("t4_vec1", 16'h0001);
        rd(AISVC, "t4_isvc", 16'h0006);
        pulse(4'h8);
        step(2);
        chk("t4_blk1", {15'b0, int_o}, 16'h0000);
        wr(AISVC, 16'h0000);
        rd(AISVC, "t4_eoi1", 16'h0004);
        step(2);
        chk("t4_blk2", {15'b0, int_o}, 16'h0000);
        wr(AISVC, 16'h0000);
        rd(AISVC, "t4_eoi2", 16'h0000);
        step(1);
        chk("t4_int3", {15'b0, int_o}, 16'h0001);
        ack("t4_vec3", 16'h0003);
        wr(AISVC, 16'h0000);

        // W1C collides with a rise: set wins; then a plain clear
        address = APEND;
        wdata   = 16'h0001;
        memwt   = 1'b1;
        src_irq = 4'h1;
        step(1);
        memwt   = 1'b0;
        src_irq = 4'h0;
        address = 12'h000;
        rd(APEND, "t5_set_wins", 16'h0001);
        wr(APEND, 16'h0001);
        rd(APEND, "t5_cleared", 16'h0000);
        chk("t5_req_kept", {15'b0, int_o}, 16'h0001);
        ack("t5_vec0", 16'h0000);
        wr(AISVC, 16'h0000);
        rd(AISVC, "t5_isvc", 16'h0000);

        // Reset while requesting
        pulse(4'h4);
        step(1);
        chk("t6_int_hi", {15'b0, int_o}, 16'h0001);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t6_int", {15'b0, int_o}, 16'h0000);
        rd(ASTAT, "t6_stat", 16'h0000);
        rd(AMASK, "t6_mask", 16'h0000);
        rd(APEND, "t6_pend", 16'h0000);
        ack("t6_vec", 16'h0000);
        chk("t6_int_post", {15'b0, int_o}, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mammal_intc.md
Name: mammal_intc

Overview:
- Priority interrupt controller for the mammal CPU. It collects up to NSRC peripheral interrupt lines and drives the single CPU INT input.
- It answers the CPU's one-cycle intack with a vector index. The CPU adds 0x07f0 to that index and fetches the ISR address from memory.
- Software controls it through memory-mapped registers on the CPU address/data/memwt bus: mask, pending, in-service/EOI and status.
- It sits between the peripherals and the CPU. vec_out is ORed onto the CPU data_in bus.

Parameters:
- NSRC, 4, number of interrupt sources, legal range 1..8; index 0 has the highest priority.
- BASE, 12'hF80, word address of register offset 0; the block decodes BASE..BASE+3.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- src_irq  in  NSRC  level inputs from peripherals, synchronous to clk; a rising edge requests service.
- address  in  12  CPU address bus.
- wdata  in  16  CPU data_out bus.
- memwt  in  1  CPU write strobe.
- rsel  out  1  high when address lies in BASE..BASE+3, combinational.
- rdata  out  16  register read data, combinational, zero when rsel=0.
- INT  out  1  interrupt request to the CPU.
- intack  in  1  CPU acknowledge, high for exactly one cycle.
- vec_out  out  16  vector during acknowledge, zero otherwise.

Behaviour:
- Reset: all of the following are zero.
  - mask, pending, inservice, prev_irq and winner.
  - state = IDLE.
  - INT, vec_out and rdata.
- Edge detect: prev_irq <= src_irq every cycle. rise[i] = src_irq[i] & ~prev_irq[i].
- A rise sets pending[i] on the next edge.
- Set has priority over any clear of the same bit in the same cycle (W1C write or ack).
- Registers (offset = address - BASE; a write is memwt & rsel):
  - Offset 0, MASK, R/W: bits [NSRC-1:0]; 1 = enabled. Bits above NSRC read 0 and ignore writes.
  - Offset 1, PENDING: reads pending. A write clears every bit where wdata=1 (write-1-to-clear).
  - Offset 2, INSERVICE: reads inservice. Any write is an EOI and clears the lowest-indexed set inservice bit; no effect if inservice=0.
  - Offset 3, STATUS, read-only: {11'b0, state(1b: 0=IDLE, 1=REQ), 1'b0, winner(3b)}. Writes are ignored.
- Eligibility:
  - elig = pending & mask & prio_allow.
  - prio_allow[i] = 1 iff no inservice bit j <= i is set (strictly nested priority).
  - cand = lowest index set in elig.
- State machine, 2 states:
  - IDLE: INT=0. If elig != 0, then winner <= cand and go to REQ.
  - REQ: INT=1. winner is frozen; a later higher-priority arrival does not change it. On intack=1:
    - pending[winner] <= 0, unless a new rise occurs that cycle;
    - inservice[winner] <= 1;
    - go to IDLE.
  - REQ, no intack: stay in REQ, INT held high.
  - REQ, software masks or clears winner before ack: stay in REQ and still deliver winner. Software must CLI before masking.
- INT is registered: it is a decode of the state register, with no combinational path from inputs.
- After an ack, INT is low for at least one cycle (the IDLE cycle) before it can re-assert.
- vec_out = {13'b0, winner} when intack & state==REQ, else 0. It is combinational from intack and valid in the same cycle (the CPU samples it at the end of INT2).
- intack while in IDLE is ignored: vec_out=0 and no state change.
- Latency: rise at edge N sets pending at N+1; IDLE enters REQ at N+2; INT is high from edge N+2.
- Reset asserted in REQ: at the next edge all state clears, and INT and vec_out are 0.

Test Plan:
- Pulse src_irq[2] (mask=0x0004 written to 0xF80) -> pending=0x0004 and INT high 2 cycles after the rise. Then intack for 1 cycle -> vec_out=0x0002 that cycle, pending=0, inservice=0x0004, INT=0 the next cycle.
- Mask=0 and pulse src_irq[1] -> INT stays 0 and PENDING reads 0x0002. Write mask=0x0002 -> INT rises 1 cycle later.
- Simultaneous rises on src[3] and src[0], mask=0xF -> vector 0 first. After ack with no EOI, src[3] is blocked (INT stays 0). Write EOI to 0xF82 -> INT rises, next ack gives vector 3.
- inservice=0x0004 and src[1] rises -> INT asserts (nesting) and vector=1. Then src[3] rises -> blocked until two EOIs.
- Write 0x0001 to 0xF81 in the same cycle src[0] rises -> pending[0] stays 1. Write 0x0001 with no rise -> pending[0] cleared.
- Assert reset while in REQ -> next cycle INT=0, STATUS=0, MASK reads 0, and intack gives vec_out=0.
